// File: rtl/fd_instr_buffer_pkg.sv
// Shared RV32I pipeline types for the fetch/decode buffer.
// The top level's optional stats outputs are enabled with FD_BUF_STATS_EN.
package rv32i_pipe_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
    } fetch_pkt_t;

    // What decode sees when nothing is buffered: a bubble executing addi x0,x0,0.
    function automatic fetch_pkt_t empty_pkt();
        fetch_pkt_t p;
        p.pc       = '0;
        p.pc_plus4 = '0;
        p.instr    = NOP_INSTR;
        return p;
    endfunction

endpackage

// File: rtl/fd_instr_buffer_if.sv
// Fetch-side and decode-side handshake bundle of the fetch/decode buffer.
// The master modport is the pipeline around the buffer; slave is the buffer.
interface fd_instr_buffer_if #(
    parameter int WIDTH = rv32i_pipe_pkg::XLEN
) ();
    logic             flush_i;
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] PCF_i;
    logic [WIDTH-1:0] PCPlus4F_i;
    logic [WIDTH-1:0] InstrF_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] PCD_o;
    logic [WIDTH-1:0] PCPlus4D_o;
    logic [WIDTH-1:0] InstrD_o;

    modport master (
        output flush_i, valid_i, PCF_i, PCPlus4F_i, InstrF_i, ready_i,
        input  ready_o, valid_o, PCD_o, PCPlus4D_o, InstrD_o
    );

    modport slave (
        input  flush_i, valid_i, PCF_i, PCPlus4F_i, InstrF_i, ready_i,
        output ready_o, valid_o, PCD_o, PCPlus4D_o, InstrD_o
    );
endinterface

// File: rtl/fd_instr_buffer_pkt_fifo.sv
// Synchronous circular FIFO of fetch packets with a single-cycle flush.
// Full/empty come from the registered count only, so ready never depends on pop.
module pkt_fifo
    import rv32i_pipe_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_flush,
    input  logic       i_push_valid,
    output logic       o_push_ready,
    input  fetch_pkt_t i_push_data,
    output logic       o_pop_valid,
    input  logic       i_pop_ready,
    output fetch_pkt_t o_pop_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fetch_pkt_t    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_push_ready = (r_count != FULL_CNT);
    assign o_pop_valid  = (r_count != '0);
    assign w_push       = i_push_valid && o_push_ready;
    assign w_pop        = o_pop_valid && i_pop_ready;
    assign o_pop_data   = r_mem[r_rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !i_flush && w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/fd_instr_buffer.sv
// Fetch-to-decode decoupling buffer: FIFO of fetch packets, NOP bubble when empty.
// Optional stall/flush counters are built when FD_BUF_STATS_EN is defined.
module fd_instr_buffer
    import rv32i_pipe_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    fd_instr_buffer_if.slave  bus
`ifdef FD_BUF_STATS_EN
    ,
    output logic [31:0]       stall_cycles_o,
    output logic [15:0]       flush_count_o
`endif
);
    fetch_pkt_t w_push_data;
    fetch_pkt_t w_head;
    fetch_pkt_t w_empty;
    logic       w_push_ready;
    logic       w_head_valid;

    assign w_push_data.pc       = bus.PCF_i;
    assign w_push_data.pc_plus4 = bus.PCPlus4F_i;
    assign w_push_data.instr    = bus.InstrF_i;
    assign w_empty              = empty_pkt();

    pkt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (bus.flush_i),
        .i_push_valid (bus.valid_i),
        .o_push_ready (w_push_ready),
        .i_push_data  (w_push_data),
        .o_pop_valid  (w_head_valid),
        .i_pop_ready  (bus.ready_i),
        .o_pop_data   (w_head)
    );

    assign bus.ready_o    = w_push_ready;
    assign bus.valid_o    = w_head_valid;
    assign bus.PCD_o      = w_head_valid ? w_head.pc       : w_empty.pc;
    assign bus.PCPlus4D_o = w_head_valid ? w_head.pc_plus4 : w_empty.pc_plus4;
    assign bus.InstrD_o   = w_head_valid ? w_head.instr    : w_empty.instr;

`ifdef FD_BUF_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [15:0] r_flush_count;

    // Stall means fetch is offering a packet the buffer cannot take.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (bus.valid_i && !w_push_ready) r_stall_cycles <= r_stall_cycles + 32'd1;
            if (bus.flush_i)                  r_flush_count  <= r_flush_count + 16'd1;
        end
    end

    assign stall_cycles_o = r_stall_cycles;
    assign flush_count_o  = r_flush_count;
`endif

endmodule

// File: tb/tb_fd_instr_buffer.sv
// Directed bench for fd_instr_buffer with a packet scoreboard queue.
// Also checks the stats counters when built with FD_BUF_STATS_EN.
module tb_fd_instr_buffer;
    import rv32i_pipe_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fd_instr_buffer_if #(.WIDTH(32)) bus ();

`ifdef FD_BUF_STATS_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    fd_instr_buffer #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus)
`ifdef FD_BUF_STATS_EN
        ,
        .stall_cycles_o (stall_cycles),
        .flush_count_o  (flush_count)
`endif
    );

    int          checks = 0;
    int          passed = 0;
    fetch_pkt_t  sb_q[$];
    logic [31:0] m_stall = '0;
    logic [15:0] m_flush = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock cycle: drive inputs, compare outputs against the model, advance the model.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                        input logic rdy, input logic fl, input logic r);
        logic       m_ready;
        fetch_pkt_t exp;
        rst            = r;
        bus.flush_i    = fl;
        bus.valid_i    = v;
        bus.PCF_i      = pc;
        bus.PCPlus4F_i = pc + 32'd4;
        bus.InstrF_i   = instr;
        bus.ready_i    = rdy;
        #1;
        m_ready = (sb_q.size() < DEPTH);
        if (sb_q.size() != 0) exp = sb_q[0];
        else begin
            exp.pc       = 32'h0;
            exp.pc_plus4 = 32'h0;
            exp.instr    = 32'h00000013;
        end
        chk("ready_o",    32'(bus.ready_o), 32'(m_ready));
        chk("valid_o",    32'(bus.valid_o), 32'(sb_q.size() != 0));
        chk("PCD_o",      bus.PCD_o,      exp.pc);
        chk("PCPlus4D_o", bus.PCPlus4D_o, exp.pc_plus4);
        chk("InstrD_o",   bus.InstrD_o,   exp.instr);
`ifdef FD_BUF_STATS_EN
        chk("stall_cycles_o", stall_cycles,       m_stall);
        chk("flush_count_o",  32'(flush_count),   32'(m_flush));
`endif
        if (r) begin
            sb_q.delete();
            m_stall = '0;
            m_flush = '0;
        end else begin
            if (v && !m_ready) m_stall = m_stall + 32'd1;
            if (fl)            m_flush = m_flush + 16'd1;
            if (fl) sb_q.delete();
            else begin
                if (sb_q.size() != 0 && rdy) void'(sb_q.pop_front());
                if (v && m_ready) begin
                    fetch_pkt_t p;
                    p.pc       = pc;
                    p.pc_plus4 = pc + 32'd4;
                    p.instr    = instr;
                    sb_q.push_back(p);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        bus.flush_i    = 1'b0;
        bus.valid_i    = 1'b0;
        bus.PCF_i      = '0;
        bus.PCPlus4F_i = '0;
        bus.InstrF_i   = '0;
        bus.ready_i    = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // idle after reset
        step(0, 32'h0, 32'h0, 0, 0, 0);
        step(0, 32'h0, 32'h0, 1, 0, 0);

        // stream-through
        step(1, 32'h0, 32'h00500093, 1, 0, 0);
        step(1, 32'h4, 32'h00100113, 1, 0, 0);
        step(1, 32'h8, 32'h002081B3, 1, 0, 0);
        step(0, 32'h0, 32'h0,        1, 0, 0);
        step(0, 32'h0, 32'h0,        1, 0, 0);

        // fill and back-pressure, 0x18 held by fetch until accepted
        step(1, 32'h10, 32'h11111111, 0, 0, 0);
        step(1, 32'h14, 32'h22222222, 0, 0, 0);
        step(1, 32'h18, 32'h33333333, 0, 0, 0);
        step(1, 32'h18, 32'h33333333, 0, 0, 0);
        step(1, 32'h18, 32'h33333333, 1, 0, 0);
        step(1, 32'h18, 32'h33333333, 1, 0, 0);
        step(0, 32'h0,  32'h0,        1, 0, 0);
        step(0, 32'h0,  32'h0,        1, 0, 0);

        // flush while full with a same-cycle push
        step(1, 32'h20,  32'h44444444, 0, 0, 0);
        step(1, 32'h24,  32'h55555555, 0, 0, 0);
        step(1, 32'h28,  32'h66666666, 0, 1, 0);
        step(1, 32'h100, 32'h77777777, 0, 0, 0);
        step(0, 32'h0,   32'h0,        1, 0, 0);
        step(0, 32'h0,   32'h0,        1, 0, 0);

        // flush with room available: the push must still be dropped
        step(1, 32'h200, 32'h88888888, 0, 0, 0);
        step(1, 32'h204, 32'h99999999, 1, 1, 0);
        step(0, 32'h0,   32'h0,        1, 0, 0);

        // mixed traffic exercising pointer wrap
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), 32'h1000 + 32'(i) * 32'd4, $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0), 0);
        end
        step(0, 32'h0, 32'h0, 1, 0, 0);
        step(0, 32'h0, 32'h0, 1, 0, 0);

        // reset mid-stream while full
        step(1, 32'h300, 32'hAAAAAAAA, 0, 0, 0);
        step(1, 32'h304, 32'hBBBBBBBB, 0, 0, 0);
        step(0, 32'h0,   32'h0,        0, 0, 1);
        step(0, 32'h0,   32'h0,        1, 0, 0);
        step(0, 32'h0,   32'h0,        1, 0, 0);

        // hold full for five cycles, then a single flush
        step(1, 32'h400, 32'hCCCCCCCC, 0, 0, 0);
        step(1, 32'h404, 32'hDDDDDDDD, 0, 0, 0);
        repeat (5) step(1, 32'h408, 32'hEEEEEEEE, 0, 0, 0);
        step(0, 32'h0, 32'h0, 0, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0, 0);
`ifdef FD_BUF_STATS_EN
        chk("stall_total", stall_cycles,     32'd5);
        chk("flush_total", 32'(flush_count), 32'd1);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
